// File: rtl/tt_um_frame_serializer_if.sv
// Pin bundle of the frame serializer: enable, data/strobe/mode/oe byte,
// bit-period divisor and the three output bytes.
interface tt_um_frame_serializer_if;
  logic       ena;
  logic [7:0] ui_in;
  logic [7:0] uio_in;
  logic [7:0] uo_out;
  logic [7:0] uio_out;
  logic [7:0] uio_oe;

  modport slave (
    input  ena, ui_in, uio_in,
    output uo_out, uio_out, uio_oe
  );

  modport master (
    output ena, ui_in, uio_in,
    input  uo_out, uio_out, uio_oe
  );
endinterface

// File: rtl/tt_um_frame_serializer.sv
// Frame serializer: on a rising load strobe, sends {HDR, data, TRL} MSB
// first on tx, each bit held DIV+1 cycles, one-shot or looping back-to-back.
module tt_um_frame_serializer #(
  parameter int                HDR_W  = 5,
  parameter logic [HDR_W-1:0]  HDR    = 5'b11110,
  parameter int                DATA_W = 5,
  parameter int                TRL_W  = 7,
  parameter logic [TRL_W-1:0]  TRL    = 7'b0101111
) (
  input  logic                     clk,
  input  logic                     rst_n,
  tt_um_frame_serializer_if.slave  bus
);

  localparam int FRAME_W = HDR_W + DATA_W + TRL_W;
  localparam logic [4:0] LAST_IDX = 5'(FRAME_W - 1);

  // Reject frame geometries the 5-bit index and data pins cannot carry.
  generate
    if (FRAME_W < 2 || FRAME_W > 32 || DATA_W < 1 || DATA_W > 5) begin : g_bad_params
      $error("tt_um_frame_serializer: illegal FRAME_W or DATA_W");
    end
  endgenerate

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t               state_r, state_s;
  logic [FRAME_W-1:0]   sr_r, sr_s;
  logic [FRAME_W-1:0]   store_r, store_s;
  logic [4:0]           idx_r, idx_s;
  logic [7:0]           div_r, div_s;
  logic                 load_q_r, load_q_s;
  logic                 done_r, done_s;

  logic                 load_ev_s;
  logic [FRAME_W-1:0]   frame_s;
  logic                 tx_s;

  assign load_ev_s = bus.ui_in[5] & ~load_q_r;
  assign frame_s   = {HDR, bus.ui_in[DATA_W-1:0], TRL};

  // State register; ena low freezes everything, reset wins over ena.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r  <= IDLE;
      sr_r     <= {FRAME_W{1'b0}};
      store_r  <= {FRAME_W{1'b0}};
      idx_r    <= 5'd0;
      div_r    <= 8'd0;
      load_q_r <= 1'b1;
      done_r   <= 1'b0;
    end else if (bus.ena) begin
      state_r  <= state_s;
      sr_r     <= sr_s;
      store_r  <= store_s;
      idx_r    <= idx_s;
      div_r    <= div_s;
      load_q_r <= load_q_s;
      done_r   <= done_s;
    end
  end

  // Next-state logic: capture on load edge, count bit periods, shift, and
  // at the last bit either return to IDLE or reload from the frame store.
  always_comb begin
    state_s  = state_r;
    sr_s     = sr_r;
    store_s  = store_r;
    idx_s    = idx_r;
    div_s    = div_r;
    load_q_s = bus.ui_in[5];
    done_s   = 1'b0;
    case (state_r)
      IDLE: begin
        if (load_ev_s) begin
          sr_s    = frame_s;
          store_s = frame_s;
          idx_s   = 5'd0;
          div_s   = bus.uio_in;
          state_s = SHIFT;
        end else begin
          state_s = IDLE;
        end
      end
      SHIFT: begin
        if (div_r != 8'd0) begin
          div_s = div_r - 8'd1;
        end else if (idx_r == LAST_IDX) begin
          done_s = 1'b1;
          idx_s  = 5'd0;
          div_s  = bus.uio_in;
          if (bus.ui_in[6]) begin
            sr_s = store_r;
          end else begin
            state_s = IDLE;
          end
        end else begin
          sr_s  = sr_r << 1;
          idx_s = idx_r + 5'd1;
          div_s = bus.uio_in;
        end
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // Output enable only masks the line; the line idles high.
  assign tx_s = (state_r == SHIFT && bus.ui_in[7]) ? sr_r[FRAME_W-1] : 1'b1;

  assign bus.uo_out  = {idx_r, done_r & bus.ena, state_r == SHIFT, tx_s};
  assign bus.uio_out = 8'h00;
  assign bus.uio_oe  = 8'h00;

endmodule

// File: tb/tb_tt_um_frame_serializer.sv
// Bench for tt_um_frame_serializer: table of one-shot frames plus hand
// sequences for loop mode, ignored reload/oe masking, ena freeze and reset.
module tb_tt_um_frame_serializer;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  tt_um_frame_serializer_if bus ();

  tt_um_frame_serializer dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    logic [4:0]  data;
    logic [7:0]  div;
    logic [16:0] exp_frame;
  } vec_t;

  vec_t       vecs[5];
  logic [7:0] sb_q[$];
  int         n_checks = 0;
  int         n_pass   = 0;

  function automatic logic [7:0] uo_word(int idx, bit done, bit busy, bit tx);
    return {5'(idx), done, busy, tx};
  endfunction

  task automatic check(string name, logic [7:0] act, logic [7:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
  endtask

  // One clock, then compare uo_out against the oldest expected entry.
  task automatic step(string name);
    @(posedge clk);
    #1;
    if (sb_q.size() == 0) begin
      n_checks++;
      $display("FAIL %s: scoreboard empty at %0t", name, $time);
    end else begin
      check(name, bus.uo_out, sb_q.pop_front());
    end
  endtask

  task automatic drain(string name);
    int guard;
    guard = 0;
    while (sb_q.size() > 0 && guard < 20000) begin
      step(name);
      guard++;
    end
  endtask

  task automatic push_frame(logic [16:0] bits, int div, bit first_done);
    for (int b = 0; b < 17; b++)
      for (int c = 0; c <= div; c++)
        sb_q.push_back(uo_word(b, first_done && b == 0 && c == 0, 1'b1, bits[16-b]));
  endtask

  task automatic push_end(int n_idle);
    sb_q.push_back(8'h05);
    for (int k = 0; k < n_idle; k++) sb_q.push_back(8'h01);
  endtask

  task automatic set_ui(bit oe, bit mode, bit load, logic [4:0] data);
    bus.ui_in = {oe, mode, load, data};
  endtask

  logic [16:0] f_loop;
  logic [16:0] f_a;
  int          i;

  initial begin
    vecs[0] = '{5'b10101, 8'd0,   17'b11110_10101_0101111};
    vecs[1] = '{5'b00000, 8'd2,   17'b11110_00000_0101111};
    vecs[2] = '{5'b11001, 8'd1,   17'b11110_11001_0101111};
    vecs[3] = '{5'b01010, 8'd3,   17'b11110_01010_0101111};
    vecs[4] = '{5'b00110, 8'd255, 17'b11110_00110_0101111};
    f_loop  = 17'b11110_11001_0101111;
    f_a     = 17'b11110_10101_0101111;

    // Reset with the strobe low.
    rst_n      = 1'b0;
    bus.ena    = 1'b1;
    bus.ui_in  = 8'h00;
    bus.uio_in = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    check("reset_uo", bus.uo_out, 8'h01);
    check("reset_uio_out", bus.uio_out, 8'h00);
    check("reset_uio_oe", bus.uio_oe, 8'h00);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Table of one-shot frames.
    for (int v = 0; v < 5; v++) begin
      set_ui(1'b1, 1'b0, 1'b1, vecs[v].data);
      bus.uio_in = vecs[v].div;
      push_frame(vecs[v].exp_frame, vecs[v].div, 1'b0);
      push_end(2);
      step("tbl_frame");
      set_ui(1'b1, 1'b0, 1'b0, vecs[v].data);
      drain("tbl_frame");
    end

    // Loop mode: three back-to-back frames, mode cleared at cycle 40.
    bus.uio_in = 8'd0;
    set_ui(1'b1, 1'b1, 1'b1, 5'b11001);
    for (int f = 0; f < 3; f++) push_frame(f_loop, 0, f > 0);
    push_end(3);
    i = 0;
    while (sb_q.size() > 0 && i < 200) begin
      step("loop");
      if (i == 0)  set_ui(1'b1, 1'b1, 1'b0, 5'b11001);
      if (i == 40) set_ui(1'b1, 1'b0, 1'b0, 5'b11001);
      i++;
    end

    // Second load mid-frame is ignored; oe low masks bits 8..10 only.
    set_ui(1'b1, 1'b0, 1'b1, 5'b10101);
    push_frame(f_a, 0, 1'b0);
    push_end(4);
    for (int b = 8; b <= 10; b++) sb_q[b][0] = 1'b1;
    i = 0;
    while (sb_q.size() > 0 && i < 200) begin
      step("reload_oe");
      if (i == 0)  bus.ui_in[5] = 1'b0;
      if (i == 4)  bus.ui_in[5] = 1'b1;
      if (i == 5)  bus.ui_in[5] = 1'b0;
      if (i == 7)  bus.ui_in[7] = 1'b0;
      if (i == 10) bus.ui_in[7] = 1'b1;
      i++;
    end

    // ena low for 10 cycles while bit 6 is on the line.
    set_ui(1'b1, 1'b0, 1'b1, 5'b10101);
    for (int b = 0; b < 7; b++) sb_q.push_back(uo_word(b, 1'b0, 1'b1, f_a[16-b]));
    for (int k = 0; k < 10; k++) sb_q.push_back(uo_word(6, 1'b0, 1'b1, f_a[10]));
    for (int b = 7; b < 17; b++) sb_q.push_back(uo_word(b, 1'b0, 1'b1, f_a[16-b]));
    push_end(2);
    i = 0;
    while (sb_q.size() > 0 && i < 200) begin
      step("ena_hold");
      if (i == 0)  bus.ui_in[5] = 1'b0;
      if (i == 6)  bus.ena = 1'b0;
      if (i == 16) bus.ena = 1'b1;
      i++;
    end

    // Reset at bit 7 with the strobe held high through and after reset.
    set_ui(1'b1, 1'b0, 1'b1, 5'b10101);
    for (int b = 0; b < 7; b++) sb_q.push_back(uo_word(b, 1'b0, 1'b1, f_a[16-b]));
    i = 0;
    while (sb_q.size() > 0 && i < 20) begin
      step("rst_pre");
      i++;
    end
    rst_n = 1'b0;
    repeat (2) sb_q.push_back(8'h01);
    drain("rst_during");
    rst_n = 1'b1;
    repeat (5) sb_q.push_back(8'h01);
    drain("rst_strobe_held");
    bus.ui_in[5] = 1'b0;
    sb_q.push_back(8'h01);
    drain("rst_strobe_low");
    bus.ui_in[5] = 1'b1;
    push_frame(f_a, 0, 1'b0);
    push_end(1);
    step("rst_restart");
    bus.ui_in[5] = 1'b0;
    drain("rst_restart");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
